// File: rtl/serial_tx_pkg.sv
// Shared types and frame-length helper for the serial transmitter.
// Parity bit appended when SERIAL_TX_PARITY_EN is defined.
package serial_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Bits per frame on the serial line
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef SERIAL_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register; MSB is the bit currently on the line.
// Zero fill means a frame drains to all zeros after its last shift.
module piso_shift_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic         shift_en,
  input  logic [W-1:0] load_val,
  output logic         msb
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else if (load_en) begin
      sr_q <= load_val;
    end else if (shift_en) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/serial_tx_shifter.sv
// MSB-first serial transmitter with load/ready handshake and gapless streaming.
// Optional even-parity bit enabled by SERIAL_TX_PARITY_EN.
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             D,
  output logic             frame,
  output logic             done
);

  localparam int unsigned FL = frame_len(WIDTH);
  localparam int unsigned CW = $clog2(FL);

  tx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_q, frame_d;
  logic            done_q, done_d;
  logic            load_en, shift_en;
  logic            last_bit;
  logic [FL-1:0]   frame_word;

`ifdef SERIAL_TX_PARITY_EN
  assign frame_word = {data_in, ^data_in};
`else
  assign frame_word = data_in;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(FL - 1));
  assign ready    = (state_q == IDLE) || last_bit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter and shift-register control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          load_en = 1'b1;
          state_d = SHIFT;
          cnt_d   = '0;
          frame_d = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          done_d = 1'b1;
          if (load) begin
            load_en = 1'b1;
            cnt_d   = '0;
            frame_d = 1'b1;
          end else begin
            // Final shift empties the register so D returns to 0
            shift_en = 1'b1;
            state_d  = IDLE;
            frame_d  = 1'b0;
          end
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  piso_shift_reg #(
    .W(FL)
  ) u_piso (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_en  (load_en),
    .shift_en (shift_en),
    .load_val (frame_word),
    .msb      (D)
  );

  assign frame = frame_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: directed cases then random traffic, checked
// against a queue-of-pending-bits model of the serial line.
module tb_serial_tx_shifter;

  localparam int unsigned WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             D;
  logic             frame;
  logic             done;

  int total = 0;
  int bad   = 0;

  // Head of q is the bit currently on the line
  bit q[$];
  bit exp_done = 1'b0;

  always #5 clock = ~clock;

  serial_tx_shifter #(
    .WIDTH(WIDTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .data_in (data_in),
    .ready   (ready),
    .D       (D),
    .frame   (frame),
    .done    (done)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ":ready"}, ready, (q.size() <= 1));
    check({ctx, ":D"},     D,     (q.size() > 0) ? q[0] : 1'b0);
    check({ctx, ":frame"}, frame, (q.size() > 0));
    check({ctx, ":done"},  done,  exp_done);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef SERIAL_TX_PARITY_EN
    q.push_back(^w);
`endif
  endtask

  // Drive inputs, advance one edge, update model, check outputs
  task automatic cycle(input string ctx, input logic l, input logic [WIDTH-1:0] d);
    bit acc;
    load    = l;
    data_in = d;
    @(posedge clock);
    if (!reset_n) begin
      q.delete();
      exp_done = 1'b0;
    end else begin
      acc      = l && (q.size() <= 1);
      exp_done = (q.size() == 1);
      if (q.size() > 0) void'(q.pop_front());
      if (acc) push_word(d);
    end
    #1 check_all(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) cycle(ctx, 1'b0, WIDTH'($urandom()));
  endtask

  // Async reset between edges, held across one edge, released off-edge
  task automatic reset_mid(input string ctx);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    exp_done = 1'b0;
    check_all({ctx, ":rst_now"});
    load = 1'b1;
    @(posedge clock);
    #1 check_all({ctx, ":rst_hold"});
    load = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    data_in = '0;
    #2 check_all("in_reset");
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1 check_all("post_reset");

    idle("idle3", 3);

    cycle("single", 1'b1, 4'b1011);
    idle("single", 6);

    cycle("b2b_a", 1'b1, 4'b1011);
    for (int i = 1; i < WIDTH; i++) cycle("b2b_a", 1'b0, 4'b0000);
`ifdef SERIAL_TX_PARITY_EN
    cycle("b2b_a", 1'b0, 4'b0000);
`endif
    cycle("b2b_b", 1'b1, 4'b0110);
    idle("b2b_b", 7);

    cycle("ign", 1'b1, 4'b1111);
    cycle("ign", 1'b1, 4'b0000);
    idle("ign", 6);

    cycle("abort", 1'b1, 4'b1011);
    cycle("abort", 1'b0, 4'b0000);
    reset_mid("abort");
    idle("abort", 1);
    cycle("after_rst", 1'b1, 4'b0101);
    idle("after_rst", 6);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) reset_mid("rnd");
      else cycle("rnd", ($urandom_range(0, 2) != 0), WIDTH'($urandom()));
    end
    idle("drain", 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
